mem_write_buffer: RTL and testbench
===================================

Name: mem_write_buffer

Overview:
- Posted-store buffer between the mips core data port and datamemory.
- Accepts stores in one cycle and drains them to memory in order when the single memory port is free and MEM_READY is high.
- Loads get data forwarded from any pending store to the same word, so software sees stores as completing immediately.
- Stalls the core only when the buffer is full and cannot drain that cycle.

Parameters:
- DEPTH, 4: number of entries; power of 2, at least 2.
- DATA_W, 32: store data width.
- ADDR_W, 32: byte address width; bits [1:0] are ignored and entries compare on [ADDR_W-1:2].

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CORE_WE  in  1  core store request (the core's MEMWRITE).
- CORE_RE  in  1  core load request.
- CORE_ADDR  in  ADDR_W  core byte address (dataaddr).
- CORE_WDATA  in  DATA_W  core store data (writedata).
- CORE_RDATA  out  DATA_W  load data returned to the core.
- STALL  out  1  core must hold its store this cycle.
- MEM_WE  out  1  write strobe to datamemory.
- MEM_ADDR  out  ADDR_W  datamemory address.
- MEM_WDATA  out  DATA_W  datamemory write data.
- MEM_RDATA  in  DATA_W  datamemory combinational read data.
- MEM_READY  in  1  memory can accept a write this cycle.
- EMPTY  out  1  no pending entries.
- COUNT  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage:
  - Circular FIFO of {word address, data} with head pointer, tail pointer and count registers.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (RESET=0, asynchronous): head=0, tail=0, count=0, so EMPTY=1 and COUNT=0. Entry data is don't-care.
- Reset asserted mid-operation discards all pending stores; they never reach memory.
- drain = !EMPTY && !CORE_RE && MEM_READY. Loads own the memory port.
- MEM_WE = drain, combinational. MEM_ADDR/MEM_WDATA = head entry when drain, otherwise MEM_ADDR = CORE_ADDR and MEM_WDATA = 0.
- enq = CORE_WE && !STALL. STALL = CORE_WE && (count==DEPTH) && !drain.
- A full buffer that drains in the same cycle accepts a store, and count stays at DEPTH.
- Count update on each CLK edge:
  - enq only: count+1.
  - drain only: count-1.
  - enq and drain together: count unchanged.
  - The head advances on drain; the tail advances on enq.
- Store latency: the entry is visible to forwarding one cycle after the accepting edge. Memory is written on the first edge where drain=1 with that entry at head.
- Forwarding (combinational): when CORE_RE=1, compare CORE_ADDR[ADDR_W-1:2] against all valid entries.
  - The youngest match (closest to the tail) drives CORE_RDATA.
  - With no match, CORE_RDATA = MEM_RDATA.
  - When CORE_RE=0, CORE_RDATA = MEM_RDATA.
- CORE_WE and CORE_RE both high is illegal. The block treats it as a store: enq may occur, the load result is don't-care, and drain is blocked because CORE_RE=1.
- Ordering: stores drain strictly in FIFO order. Duplicate addresses occupy separate entries.
- A store arriving while CORE_RE is held for many cycles only fills the buffer. There is no deadlock, because releasing CORE_RE resumes draining.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a store whose word address matches a valid entry overwrites that entry's data in place, with no new entry and no count change.
  - This applies only if the matching entry is not the head being drained in the same cycle; otherwise the store enqueues normally.
  - STALL is suppressed for coalescing stores even when full.
- Undefined: every accepted store allocates a new entry as described above.

Test Plan:
- Reset then idle with MEM_READY=1: store 0x11111111 to 0x40 → COUNT=1 after the edge, MEM_WE=1 with MEM_ADDR=0x40 next cycle, EMPTY=1 after that.
- MEM_READY=0: 4 stores to 0x00,0x04,0x08,0x0C → COUNT=4. A 5th store gives STALL=1. Raise MEM_READY → the 5th is accepted in the same cycle as the 0x00 drain and COUNT stays 4.
- MEM_READY=0: store 0xAAAA to 0x20 then 0xBBBB to 0x20, then load 0x20 → CORE_RDATA=0xBBBB. Load 0x24 returns MEM_RDATA.
- Drain ordering: with MEM_READY=0, store 0x08,0x10,0x18 with data 1,2,3. Release MEM_READY with a CORE_RE=1 cycle inserted → MEM_WE pulses in order 1,2,3, and there is no MEM_WE in the load cycle.
- Assert RESET low mid-drain with COUNT=3 → COUNT=0 and EMPTY=1 immediately; no further MEM_WE.
- WB_COALESCE_EN: MEM_READY=0, full with 0x00..0x0C, then store 0x99 to 0x04 → STALL=0, COUNT=4, and the drain sequence shows 0x99 at 0x04.

Source files
------------

// File: rtl/mem_write_buffer_if.sv
// Core-side and memory-side signal bundle for the posted-store write buffer.
// The slave modport is the buffer's view; master is the core/memory side.
interface mem_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              CORE_WE;
  logic              CORE_RE;
  logic [ADDR_W-1:0] CORE_ADDR;
  logic [DATA_W-1:0] CORE_WDATA;
  logic [DATA_W-1:0] CORE_RDATA;
  logic              STALL;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_READY;
  logic              EMPTY;
  logic [CNT_W-1:0]  COUNT;

  modport slave (
    input  CORE_WE, CORE_RE, CORE_ADDR, CORE_WDATA, MEM_RDATA, MEM_READY,
    output CORE_RDATA, STALL, MEM_WE, MEM_ADDR, MEM_WDATA, EMPTY, COUNT
  );

  modport master (
    output CORE_WE, CORE_RE, CORE_ADDR, CORE_WDATA, MEM_RDATA, MEM_READY,
    input  CORE_RDATA, STALL, MEM_WE, MEM_ADDR, MEM_WDATA, EMPTY, COUNT
  );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO between core data port and data memory, with load forwarding.
// Optional macro WB_COALESCE_EN: stores hitting a pending word overwrite it in place.
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  mem_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              empty;
  logic              full;
  logic              drain;
  logic              enq;
  logic              coal;
  logic              stall;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic [WA_W-1:0]   core_wa;

  assign core_wa = bus.CORE_ADDR[ADDR_W-1:2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Loads own the single memory port, so a pending load blocks draining.
  assign drain   = !empty && !bus.CORE_RE && bus.MEM_READY;

  // Walk valid entries oldest to youngest; the last match is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == core_wa)) begin
        hit     = 1'b1;
        hit_idx = head_q + PTR_W'(k);
      end
    end
  end

`ifdef WB_COALESCE_EN
  assign coal = bus.CORE_WE && hit && !(drain && (hit_idx == head_q));
`else
  assign coal = 1'b0;
`endif

  assign stall = bus.CORE_WE && full && !drain && !coal;
  assign enq   = bus.CORE_WE && !stall && !coal;

  always_comb begin
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_d = drain ? head_q + PTR_W'(1) : head_q;
    tail_d = enq   ? tail_q + PTR_W'(1) : tail_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; validity comes from head/count alone.
  always_ff @(posedge CLK) begin
    if (enq) begin
      addr_q[tail_q] <= core_wa;
      data_q[tail_q] <= bus.CORE_WDATA;
    end
    if (coal) begin
      data_q[hit_idx] <= bus.CORE_WDATA;
    end
  end

  assign bus.MEM_WE     = drain;
  assign bus.MEM_ADDR   = drain ? {addr_q[head_q], 2'b00} : bus.CORE_ADDR;
  assign bus.MEM_WDATA  = drain ? data_q[head_q] : '0;
  assign bus.CORE_RDATA = (bus.CORE_RE && hit) ? data_q[hit_idx] : bus.MEM_RDATA;
  assign bus.STALL      = stall;
  assign bus.EMPTY      = empty;
  assign bus.COUNT      = count_q;
endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: a queue of expected memory writes
// is pushed as stores are accepted and popped as MEM_WE pulses appear.
module tb_mem_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic CLK;
  logic RESET;
  int   n_tests;
  int   n_fail;
  ent_t sbq[$];

  mem_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) bus ();

  mem_write_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {16'hD00D, a[15:0]};
  endfunction

  assign bus.MEM_RDATA = mem_val(bus.CORE_ADDR);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of core/memory stimulus, checked against the queue model at negedge.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic ready);
    bit          drain_m;
    bit          coal_m;
    bit          stall_m;
    int          j;
    logic [31:0] rd_exp;
    ent_t        e;
    bus.CORE_WE    = we;
    bus.CORE_RE    = re;
    bus.CORE_ADDR  = addr;
    bus.CORE_WDATA = wdata;
    bus.MEM_READY  = ready;
    @(negedge CLK);
    drain_m = (sbq.size() != 0) && !re && ready;
    check_val("count", 32'(bus.COUNT), 32'(sbq.size()));
    check_val("empty", 32'(bus.EMPTY), 32'(sbq.size() == 0));
    check_val("mem_we", 32'(bus.MEM_WE), 32'(drain_m));
    if (drain_m) begin
      check_val("mem_addr", bus.MEM_ADDR, sbq[0].addr);
      check_val("mem_wdata", bus.MEM_WDATA, sbq[0].data);
    end else begin
      check_val("mem_addr_idle", bus.MEM_ADDR, addr);
      check_val("mem_wdata_idle", bus.MEM_WDATA, 32'h0);
    end
    j = -1;
    foreach (sbq[i]) if (sbq[i].addr[31:2] == addr[31:2]) j = i;
    if (!(we && re)) begin
      rd_exp = mem_val(addr);
      if (re && j >= 0) rd_exp = sbq[j].data;
      check_val("core_rdata", bus.CORE_RDATA, rd_exp);
    end
    coal_m = 1'b0;
`ifdef WB_COALESCE_EN
    coal_m = we && (j >= 0) && !((j == 0) && drain_m);
`endif
    stall_m = we && (sbq.size() == DEPTH) && !drain_m && !coal_m;
    check_val("stall", 32'(bus.STALL), 32'(stall_m));
    if (coal_m) sbq[j].data = wdata;
    if (drain_m) void'(sbq.pop_front());
    if (we && !stall_m && !coal_m) begin
      e.addr = {addr[31:2], 2'b00};
      e.data = wdata;
      sbq.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h100, 32'h0, ready);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET = 1'b0;
    bus.CORE_WE = 1'b0; bus.CORE_RE = 1'b0; bus.CORE_ADDR = '0;
    bus.CORE_WDATA = '0; bus.MEM_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_count", 32'(bus.COUNT), 32'd0);
    check_val("rst_empty", 32'(bus.EMPTY), 32'd1);
    check_val("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Single store, drained the following cycle.
    step(1'b1, 1'b0, 32'h40, 32'h11111111, 1'b1);
    check_val("t1_count1", 32'(bus.COUNT), 32'd1);
    idle(2, 1'b1);
    check_val("t1_empty", 32'(bus.EMPTY), 32'd1);

    // Fill, stall, then accept while draining the head.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h100 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 32'h50, 32'h55, 1'b0);
    step(1'b1, 1'b0, 32'h50, 32'h55, 1'b1);
    check_val("t2_count_full", 32'(bus.COUNT), 32'd4);
    idle(6, 1'b1);

    // Forwarding of the youngest matching store, and a miss.
    step(1'b1, 1'b0, 32'h20, 32'hAAAA, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'hBBBB, 1'b0);
    step(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h24, 32'h0, 1'b0);
    idle(4, 1'b1);

    // Drain order with a load cycle stealing the port.
    step(1'b1, 1'b0, 32'h08, 32'h1, 1'b0);
    step(1'b1, 1'b0, 32'h10, 32'h2, 1'b0);
    step(1'b1, 1'b0, 32'h18, 32'h3, 1'b0);
    step(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h18, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h60 + 32'(i * 4), 32'h70 + 32'(i), 1'b0);
    bus.CORE_WE = 1'b0; bus.CORE_RE = 1'b0; bus.MEM_READY = 1'b1;
    @(negedge CLK);
    check_val("t5_pre_we", 32'(bus.MEM_WE), 32'd1);
    check_val("t5_pre_count", 32'(bus.COUNT), 32'd3);
    #2 RESET = 1'b0;
    #1;
    check_val("t5_count", 32'(bus.COUNT), 32'd0);
    check_val("t5_empty", 32'(bus.EMPTY), 32'd1);
    check_val("t5_mem_we", 32'(bus.MEM_WE), 32'd0);
    sbq.delete();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    idle(3, 1'b1);

`ifdef WB_COALESCE_EN
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h200 + 32'(i), 1'b0);
    step(1'b1, 1'b0, 32'h04, 32'h99, 1'b0);
    check_val("t6_count", 32'(bus.COUNT), 32'd4);
    idle(6, 1'b1);
`endif

    // Randomised mix of stores, loads and back-pressure over a small address set.
    for (int i = 0; i < 400; i++) begin
      logic w;
      logic r;
      w = ($urandom_range(0, 2) == 0);
      r = !w && ($urandom_range(0, 3) == 0);
      step(w, r, 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
           $urandom, ($urandom_range(0, 2) != 0));
    end
    idle(8, 1'b1);
    check_val("final_empty", 32'(bus.EMPTY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
